// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Groups every handshake and ALU bus signal of alu_arbiter.
//   slave  : the arbiter side (takes requests, drives responses and the ALU).
//   master : the environment side (requesters plus the ALU itself).
//   Signals:
//     reqN_valid/ready/cmd/a/b/sc  request channel of requester N (N=0,1)
//     respN_valid/ready            response channel of requester N
//     resp_rslt/resp_flags         captured result, shared by both responses
//     alu_cmd/inA/inB/sc_i         operands driven to the ALU
//     alu_rslt/sc_o/pari/zero/equal  results returned by the ALU
interface alu_arbiter_if #(
    parameter int DW = 8,
    parameter int CW = 4
);
    logic          req0_valid;
    logic          req0_ready;
    logic [CW-1:0] req0_cmd;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic          req0_sc;
    logic          req1_valid;
    logic          req1_ready;
    logic [CW-1:0] req1_cmd;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          req1_sc;
    logic          resp0_valid;
    logic          resp0_ready;
    logic          resp1_valid;
    logic          resp1_ready;
    logic [DW-1:0] resp_rslt;
    logic [3:0]    resp_flags;
    logic [CW-1:0] alu_cmd;
    logic [DW-1:0] alu_inA;
    logic [DW-1:0] alu_inB;
    logic          alu_sc_i;
    logic [DW-1:0] alu_rslt;
    logic          alu_sc_o;
    logic          alu_pari;
    logic          alu_zero;
    logic          alu_equal;

    modport slave (
        input  req0_valid, req0_cmd, req0_a, req0_b, req0_sc,
        input  req1_valid, req1_cmd, req1_a, req1_b, req1_sc,
        input  resp0_ready, resp1_ready,
        input  alu_rslt, alu_sc_o, alu_pari, alu_zero, alu_equal,
        output req0_ready, req1_ready, resp0_valid, resp1_valid,
        output resp_rslt, resp_flags,
        output alu_cmd, alu_inA, alu_inB, alu_sc_i
    );

    modport master (
        output req0_valid, req0_cmd, req0_a, req0_b, req0_sc,
        output req1_valid, req1_cmd, req1_a, req1_b, req1_sc,
        output resp0_ready, resp1_ready,
        output alu_rslt, alu_sc_o, alu_pari, alu_zero, alu_equal,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid,
        input  resp_rslt, resp_flags,
        input  alu_cmd, alu_inA, alu_inB, alu_sc_i
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one ALU between two requesters. A granted request is latched into
//   the ALU operand registers, held for EXEC_CYCLES cycles, then the ALU
//   result/flags are captured and returned to the winner. One op in flight.
//   Ports:
//     clk     clock
//     reset   synchronous, active-high reset
//     bus_io  alu_arbiter_if.slave (request, response and ALU buses)
//   Configuration macro:
//     ALU_ARB_FIXED_PRIO_EN  defined: req0 always wins ties (fixed priority).
//                            undefined: round-robin on ties (default).
module alu_arbiter #(
    parameter int DW          = 8,
    parameter int CW          = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus_io
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CW-1:0] NOP_CMD  = {CW{1'b1}};
    localparam logic [3:0]    LAST_CNT = 4'(EXEC_CYCLES - 1);

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [CW-1:0] alu_cmd_q, alu_cmd_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          alu_sc_q, alu_sc_d;
    logic [DW-1:0] rslt_q, rslt_d;
    logic [3:0]    flags_q, flags_d;
    logic          resp0_valid_q, resp0_valid_d;
    logic          resp1_valid_q, resp1_valid_d;

    logic          win_s;      // requester that would be granted now
    logic          ready0_s;
    logic          ready1_s;
    logic          accept_s;
    logic          resp_ready_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Fixed priority: req0 wins whenever it is valid, so no grant history is kept.
    always_comb begin
        if (bus_io.req0_valid) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end
`else
    logic last_grant_q;

    // Round-robin grant: on a tie the requester that was not served last wins.
    always_comb begin
        if (bus_io.req0_valid && bus_io.req1_valid) begin
            win_s = ~last_grant_q;
        end else if (bus_io.req0_valid) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
    end

    // Grant history, updated only when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (accept_s) begin
            last_grant_q <= win_s;
        end else begin
            last_grant_q <= last_grant_q;
        end
    end
`endif

    // Ready is offered only in IDLE and only to the winner; win_s is 1 when
    // nobody is valid, so ready1 still needs req1_valid.
    assign ready0_s     = (state_q == ST_IDLE) && bus_io.req0_valid && !win_s;
    assign ready1_s     = (state_q == ST_IDLE) && bus_io.req1_valid && win_s;
    assign accept_s     = ready0_s || ready1_s;
    // Only the granted requester's consume strobe matters.
    assign resp_ready_s = grant_q ? bus_io.resp1_ready : bus_io.resp0_ready;

    // Next-state and registered-output logic of the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        alu_cmd_d     = alu_cmd_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sc_d      = alu_sc_q;
        rslt_d        = rslt_q;
        flags_d       = flags_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    grant_d = win_s;
                    cnt_d   = 4'd0;
                    state_d = ST_EXEC;
                    if (win_s) begin
                        alu_cmd_d = bus_io.req1_cmd;
                        alu_a_d   = bus_io.req1_a;
                        alu_b_d   = bus_io.req1_b;
                        alu_sc_d  = bus_io.req1_sc;
                    end else begin
                        alu_cmd_d = bus_io.req0_cmd;
                        alu_a_d   = bus_io.req0_a;
                        alu_b_d   = bus_io.req0_b;
                        alu_sc_d  = bus_io.req0_sc;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == LAST_CNT) begin
                    // Last hold cycle: sample the ALU and park it on NOP.
                    rslt_d        = bus_io.alu_rslt;
                    flags_d       = {bus_io.alu_sc_o, bus_io.alu_pari,
                                     bus_io.alu_zero, bus_io.alu_equal};
                    alu_cmd_d     = NOP_CMD;
                    alu_a_d       = {DW{1'b0}};
                    alu_b_d       = {DW{1'b0}};
                    alu_sc_d      = 1'b0;
                    cnt_d         = 4'd0;
                    resp0_valid_d = ~grant_q;
                    resp1_valid_d = grant_q;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_s) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                cnt_d         = 4'd0;
                alu_cmd_d     = NOP_CMD;
                alu_a_d       = {DW{1'b0}};
                alu_b_d       = {DW{1'b0}};
                alu_sc_d      = 1'b0;
                resp0_valid_d = 1'b0;
                resp1_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            cnt_q         <= 4'd0;
            alu_cmd_q     <= NOP_CMD;
            alu_a_q       <= {DW{1'b0}};
            alu_b_q       <= {DW{1'b0}};
            alu_sc_q      <= 1'b0;
            rslt_q        <= {DW{1'b0}};
            flags_q       <= 4'd0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            alu_cmd_q     <= alu_cmd_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sc_q      <= alu_sc_d;
            rslt_q        <= rslt_d;
            flags_q       <= flags_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    assign bus_io.req0_ready  = ready0_s;
    assign bus_io.req1_ready  = ready1_s;
    assign bus_io.resp0_valid = resp0_valid_q;
    assign bus_io.resp1_valid = resp1_valid_q;
    assign bus_io.resp_rslt   = rslt_q;
    assign bus_io.resp_flags  = flags_q;
    assign bus_io.alu_cmd     = alu_cmd_q;
    assign bus_io.alu_inA     = alu_a_q;
    assign bus_io.alu_inB     = alu_b_q;
    assign bus_io.alu_sc_i    = alu_sc_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. dut_a uses EXEC_CYCLES=1, dut_b uses
//   EXEC_CYCLES=3. A small behavioural ALU answers each DUT's ALU bus.
//   Inputs change on the falling edge; outputs are sampled there too.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DW(8), .CW(4)) a_if ();
    alu_arbiter_if #(.DW(8), .CW(4)) b_if ();

    alu_arbiter #(.DW(8), .CW(4), .EXEC_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .bus_io(a_if.slave));
    alu_arbiter #(.DW(8), .CW(4), .EXEC_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .bus_io(b_if.slave));

    // Returns {sc_o, pari, zero, equal, rslt[7:0]}.
    function automatic logic [11:0] alu_f(logic [3:0] c, logic [7:0] x, logic [7:0] y, logic s);
        logic [8:0] s9;
        logic [7:0] r;
        logic       co;
        co = 1'b0;
        s9 = 9'd0;
        case (c)
            4'b0000: begin s9 = {1'b0, x} + {1'b0, y} + {8'd0, s}; r = s9[7:0]; co = s9[8]; end
            4'b0001: r = x << y[2:0];
            4'b0010: r = x >> y[2:0];
            4'b0100: r = x | y;
            4'b1101: r = x - y;
            default: r = 8'd0;
        endcase
        return {co, ^r, (r == 8'd0), (x == y), r};
    endfunction

    assign {a_if.alu_sc_o, a_if.alu_pari, a_if.alu_zero, a_if.alu_equal, a_if.alu_rslt} =
        alu_f(a_if.alu_cmd, a_if.alu_inA, a_if.alu_inB, a_if.alu_sc_i);
    assign {b_if.alu_sc_o, b_if.alu_pari, b_if.alu_zero, b_if.alu_equal, b_if.alu_rslt} =
        alu_f(b_if.alu_cmd, b_if.alu_inA, b_if.alu_inB, b_if.alu_sc_i);

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(logic v, logic [3:0] c, logic [7:0] x, logic [7:0] y, logic s);
        a_if.req0_valid = v; a_if.req0_cmd = c; a_if.req0_a = x; a_if.req0_b = y; a_if.req0_sc = s;
    endtask

    task automatic set_req1(logic v, logic [3:0] c, logic [7:0] x, logic [7:0] y, logic s);
        a_if.req1_valid = v; a_if.req1_cmd = c; a_if.req1_a = x; a_if.req1_b = y; a_if.req1_sc = s;
    endtask

    // Single req0 op on dut_a with resp0_ready high: checks latency and values.
    task automatic single0(string tag, logic [3:0] c, logic [7:0] x, logic [7:0] y, logic s,
                           logic [7:0] er, logic [3:0] ef);
        set_req0(1'b1, c, x, y, s);
        #1;
        chk({tag, " ready0"}, a_if.req0_ready, 1);
        chk({tag, " ready1"}, a_if.req1_ready, 0);
        @(negedge clk);                       // T+1: EXEC
        a_if.req0_valid = 1'b0;
        chk({tag, " exec cmd"}, a_if.alu_cmd, c);
        chk({tag, " exec inA"}, a_if.alu_inA, x);
        chk({tag, " exec inB"}, a_if.alu_inB, y);
        chk({tag, " exec resp0"}, a_if.resp0_valid, 0);
        @(negedge clk);                       // T+2: RESP
        chk({tag, " resp0_valid"}, a_if.resp0_valid, 1);
        chk({tag, " resp1_valid"}, a_if.resp1_valid, 0);
        chk({tag, " rslt"}, a_if.resp_rslt, er);
        chk({tag, " flags"}, a_if.resp_flags, ef);
        chk({tag, " resp cmd nop"}, a_if.alu_cmd, 4'b1111);
        @(negedge clk);                       // T+3: IDLE again
        chk({tag, " resp0 done"}, a_if.resp0_valid, 0);
    endtask

    // Simultaneous pair on dut_a; 'first' is the expected first winner.
    task automatic pair(string tag, int first,
                        logic [3:0] c0, logic [7:0] x0, logic [7:0] y0, logic [7:0] r0,
                        logic [3:0] c1, logic [7:0] x1, logic [7:0] y1, logic [7:0] r1);
        logic [7:0] rf, ro;
        rf = (first == 0) ? r0 : r1;
        ro = (first == 0) ? r1 : r0;
        set_req0(1'b1, c0, x0, y0, 1'b0);
        set_req1(1'b1, c1, x1, y1, 1'b0);
        #1;
        chk({tag, " ready0"}, a_if.req0_ready, (first == 0));
        chk({tag, " ready1"}, a_if.req1_ready, (first == 1));
        @(negedge clk);
        if (first == 0) a_if.req0_valid = 1'b0; else a_if.req1_valid = 1'b0;
        @(negedge clk);
        chk({tag, " first valid"}, (first == 0) ? a_if.resp0_valid : a_if.resp1_valid, 1);
        chk({tag, " other not valid"}, (first == 0) ? a_if.resp1_valid : a_if.resp0_valid, 0);
        chk({tag, " other not ready"}, (first == 0) ? a_if.req1_ready : a_if.req0_ready, 0);
        chk({tag, " first rslt"}, a_if.resp_rslt, rf);
        @(negedge clk);
        #1;
        chk({tag, " other ready"}, (first == 0) ? a_if.req1_ready : a_if.req0_ready, 1);
        @(negedge clk);
        if (first == 0) a_if.req1_valid = 1'b0; else a_if.req0_valid = 1'b0;
        @(negedge clk);
        chk({tag, " second valid"}, (first == 0) ? a_if.resp1_valid : a_if.resp0_valid, 1);
        chk({tag, " second rslt"}, a_if.resp_rslt, ro);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int second_first;
        reset = 1'b1;
        set_req0(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
        set_req1(1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
        a_if.resp0_ready = 1'b1; a_if.resp1_ready = 1'b1;
        b_if.req0_valid = 1'b0; b_if.req0_cmd = 4'd0; b_if.req0_a = 8'd0; b_if.req0_b = 8'd0; b_if.req0_sc = 1'b0;
        b_if.req1_valid = 1'b0; b_if.req1_cmd = 4'd0; b_if.req1_a = 8'd0; b_if.req1_b = 8'd0; b_if.req1_sc = 1'b0;
        b_if.resp0_ready = 1'b1; b_if.resp1_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst ready0", a_if.req0_ready, 0);
        chk("rst ready1", a_if.req1_ready, 0);
        chk("rst resp0_valid", a_if.resp0_valid, 0);
        chk("rst resp1_valid", a_if.resp1_valid, 0);
        chk("rst rslt", a_if.resp_rslt, 0);
        chk("rst flags", a_if.resp_flags, 0);
        chk("rst alu_cmd", a_if.alu_cmd, 4'b1111);
        chk("rst alu_inA", a_if.alu_inA, 0);
        chk("rst alu_inB", a_if.alu_inB, 0);
        chk("rst alu_sc_i", a_if.alu_sc_i, 0);
        chk("rst b alu_cmd", b_if.alu_cmd, 4'b1111);
        reset = 1'b0;

        // 1: single add 1+2
        single0("t1", 4'b0000, 8'd1, 8'd2, 1'b0, 8'd3, 4'b0000);

        // 2: pair right after reset -> req0 first, then req1
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pair("t2a", 0, 4'b0001, 8'd2, 8'd1, 8'd4, 4'b0010, 8'd4, 8'd1, 8'd2);
        // req0 alone (5+5+1=11), leaving req0 as last grant
        single0("t2s", 4'b0000, 8'd5, 8'd5, 1'b1, 8'd11, 4'b0101);
`ifdef ALU_ARB_FIXED_PRIO_EN
        second_first = 0;
`else
        second_first = 1;
`endif
        pair("t2b", second_first, 4'b0000, 8'd1, 8'd1, 8'd2, 4'b0100, 8'd8, 8'd1, 8'd9);

        // 3: response back-pressure on resp0 while req1 waits
        a_if.resp0_ready = 1'b0;
        set_req0(1'b1, 4'b0001, 8'd3, 8'd2, 1'b0);
        @(negedge clk);
        a_if.req0_valid = 1'b0;
        set_req1(1'b1, 4'b0010, 8'd8, 8'd2, 1'b0);
        #1;
        chk("t3 exec ready1", a_if.req1_ready, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t3 hold resp0_valid", a_if.resp0_valid, 1);
            chk("t3 hold rslt", a_if.resp_rslt, 8'd12);
            chk("t3 hold ready1", a_if.req1_ready, 0);
            chk("t3 hold resp1_valid", a_if.resp1_valid, 0);
            @(negedge clk);
        end
        a_if.resp0_ready = 1'b1;
        #1;
        chk("t3 release ready1", a_if.req1_ready, 0);
        @(negedge clk);
        #1;
        chk("t3 after resp0_valid", a_if.resp0_valid, 0);
        chk("t3 after ready1", a_if.req1_ready, 1);
        @(negedge clk);
        a_if.req1_valid = 1'b0;
        @(negedge clk);
        chk("t3 resp1_valid", a_if.resp1_valid, 1);
        chk("t3 resp1 rslt", a_if.resp_rslt, 8'd2);
        @(negedge clk);

        // 4: compare 1 vs 1 -> equal and zero set; NOP outside EXEC
        chk("t4 idle cmd nop", a_if.alu_cmd, 4'b1111);
        single0("t4", 4'b1101, 8'd1, 8'd1, 1'b0, 8'd0, 4'b0011);
        chk("t4 idle cmd nop after", a_if.alu_cmd, 4'b1111);

        // 5: reset during EXEC abandons the op
        set_req0(1'b1, 4'b0000, 8'd7, 8'd7, 1'b0);
        @(negedge clk);
        a_if.req0_valid = 1'b0;
        chk("t5 in exec", a_if.alu_cmd, 4'b0000);
        reset = 1'b1;
        @(negedge clk);
        chk("t5 rst resp0_valid", a_if.resp0_valid, 0);
        chk("t5 rst alu_cmd", a_if.alu_cmd, 4'b1111);
        chk("t5 rst alu_inA", a_if.alu_inA, 0);
        chk("t5 rst rslt", a_if.resp_rslt, 0);
        chk("t5 rst flags", a_if.resp_flags, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("t5 no resp0", a_if.resp0_valid, 0);
        chk("t5 no resp1", a_if.resp1_valid, 0);
        set_req1(1'b1, 4'b0100, 8'd12, 8'd2, 1'b0);
        #1;
        chk("t5 ready1", a_if.req1_ready, 1);
        @(negedge clk);
        a_if.req1_valid = 1'b0;
        @(negedge clk);
        chk("t5 resp1_valid", a_if.resp1_valid, 1);
        chk("t5 rslt", a_if.resp_rslt, 8'd14);
        chk("t5 flags", a_if.resp_flags, 4'b0100);
        @(negedge clk);

        // 6: EXEC_CYCLES=3 instance, 9+4+1=14
        b_if.req1_valid = 1'b1; b_if.req1_cmd = 4'b0000; b_if.req1_a = 8'd9;
        b_if.req1_b = 8'd4; b_if.req1_sc = 1'b1;
        #1;
        chk("t6 ready1", b_if.req1_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b_if.req1_valid = 1'b0;
            chk("t6 exec cmd", b_if.alu_cmd, 4'b0000);
            chk("t6 exec inA", b_if.alu_inA, 8'd9);
            chk("t6 exec inB", b_if.alu_inB, 8'd4);
            chk("t6 exec sc", b_if.alu_sc_i, 1);
            chk("t6 exec no resp", b_if.resp1_valid, 0);
        end
        @(negedge clk);
        chk("t6 resp1_valid", b_if.resp1_valid, 1);
        chk("t6 resp0_valid", b_if.resp0_valid, 0);
        chk("t6 rslt", b_if.resp_rslt, 8'd14);
        chk("t6 flags", b_if.resp_flags, 4'b0100);
        chk("t6 resp cmd nop", b_if.alu_cmd, 4'b1111);
        @(negedge clk);
        chk("t6 done", b_if.resp1_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
